lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side PRBS checker for the serial stream from the LFSR_code generator.
//  Self-synchronises to the incoming bit stream and declares lock.
//  While locked, it predicts each bit locally, counts bit errors and drops lock on an error burst.
//  Sits at the far end of a serial link or loopback, fed one bit per qualified clock.
// PARAMETERS
//  WIDTH        32            LFSR length; history register width
//  TAPS         32'h80200003  lag mask; bit k-1 set => lag k in recurrence (x^32+x^22+x^2+x+1)
//  LOCK_COUNT   64            consecutive matching bits needed after fill to declare lock
//  UNLOCK_WIN   128           loss-of-lock window length, in valid bits
//  UNLOCK_ERRS  8             errors within one window that force loss of lock
//  CNT_W        32            width of err_count / bit_count
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous, active-low reset
//  in_valid     in   1      in_bit qualifier; nothing advances when low
//  in_bit       in   1      received serial bit (generator Q)
//  clear_counts in   1      synchronous clear of err_count and bit_count
//  locked       out  1      1 = checker synchronised (LOCKED state)
//  bit_err      out  1      1-cycle pulse: last compared bit mismatched while locked
//  err_count    out  CNT_W  saturating count of errored bits while locked
//  bit_count    out  CNT_W  saturating count of bits compared while locked
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=SEARCH; history, fill, match, window counters =0.
//   locked=0, bit_err=0, err_count=0, bit_count=0. Also applies mid-operation: next cycle all outputs are 0.
//  Recurrence: hist[0]=newest bit, hist[k-1]=bit k ago; pred = ^(hist & TAPS).
//   The generator is bound to produce streams satisfying b[n] = pred.
//  Every step below occurs only on a posedge with in_valid=1; otherwise all state holds and bit_err=0.
//  SEARCH: hist <= {hist[WIDTH-2:0], in_bit}.
//   First WIDTH bits fill only; fill_cnt counts to WIDTH.
//   After fill: in_bit==pred -> match_cnt+1, else match_cnt=0.
//   When match_cnt reaches LOCK_COUNT with hist!=0 -> LOCKED; locked=1 from the next cycle.
//   If hist==0 at that point -> match_cnt=0, stay in SEARCH. An all-zero stream never locks.
//  LOCKED: hist shifts in pred, not in_bit, so the local generator free-runs and each error counts once.
//   bit_count+1 on every valid bit.
//   On in_bit!=pred: bit_err=1 next cycle; err_count+1; win_err+1.
//   win_pos counts valid bits from LOCKED entry, wraps at UNLOCK_WIN, clears win_err on wrap.
//   When win_err reaches UNLOCK_ERRS -> SEARCH: fill_cnt, match_cnt, win_* cleared; locked=0 next cycle.
//   err_count and bit_count hold their values.
//  Latency: locked, bit_err and the counters update 1 clk after the sampling posedge.
//  Counters saturate at all-ones; no wrap.
//  clear_counts has priority over increment, except the current cycle's event still counts:
//   result = 0 + inc (err_count=1 if an error coincides).
//  clear_counts affects neither state nor lock.
// STRUCTURE
//  Shared header lfsr_defs.vh, also used by LFSR_code:
//   LFSR_WIDTH, LFSR_TAPS default, state encodings ST_SEARCH=1'b0, ST_LOCKED=1'b1.
//  One sub-module: lfsr_sat_counter (CNT_W, inc, clr) instantiated for err_count and bit_count.
//  Top holds history register, predictor XOR-reduce, FSM, and fill/match/window counters.
// TESTING
//  1) rst_n low 2 clk; then stream 200 bits from LFSR_code seeded 32'h00003039, in_valid=1.
//     -> locked rises 1 clk after the 96th bit (32 fill + 64 match); err_count=0; bit_count=104 at end.
//  2) As 1, invert bit #150. -> exactly one bit_err pulse 1 clk after it; err_count=1; locked stays 1.
//  3) Invert bits #106..#113 (8 consecutive, one window). -> locked falls 1 clk after bit #113.
//     Clean bits after that: relock 1 clk after bit #209; err_count=8 retained.
//  4) rst_n low, then 300 bits of 0 with in_valid=1. -> locked never asserts; bit_count=0.
//  5) As 1, but in_valid high only every 3rd clk and in_bit=X when low.
//     -> lock at the same bit index (96); no X propagation on outputs.
//  6) Locked; clear_counts coincident with errored bit -> err_count=1, bit_count=1.
//     Then rst_n low 1 clk mid-stream -> next cycle locked=0, err_count=0, bit_count=0.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared LFSR constants and checker state encoding
package lfsr_checker_pkg;

    localparam int          LFSR_WIDTH = 32;
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

endpackage

// File: rtl/lfsr_sat_counter.sv
// rtl/lfsr_sat_counter.sv - saturating event counter with synchronous clear
module lfsr_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // A clear still keeps the event of the same cycle.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = CNT_W'(inc);
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS receive checker with lock and error counting
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int               WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(LFSR_TAPS),
    parameter int               LOCK_COUNT  = 64,
    parameter int               UNLOCK_WIN  = 128,
    parameter int               UNLOCK_ERRS = 8,
    parameter int               CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_counts,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WPOS_W  = $clog2(UNLOCK_WIN + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WPOS_W-1:0]  WPOS_LAST  = WPOS_W'(UNLOCK_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(UNLOCK_ERRS - 1);

    chk_state_e         state_d, state_q;
    logic [WIDTH-1:0]   hist_d, hist_q;
    logic [FILL_W-1:0]  fill_d, fill_q;
    logic [MATCH_W-1:0] match_d, match_q;
    logic [WPOS_W-1:0]  win_pos_d, win_pos_q;
    logic [WERR_W-1:0]  win_err_d, win_err_q;
    logic               bit_err_d, bit_err_q;
    logic               pred;
    logic               mismatch;
    logic               err_inc;
    logic               bit_inc;

    assign pred     = ^(hist_q & TAPS);
    assign mismatch = in_bit ^ pred;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_pos_d = win_pos_q;
        win_err_d = win_err_q;
        bit_err_d = 1'b0;
        err_inc   = 1'b0;
        bit_inc   = 1'b0;
        if (in_valid) begin
            if (state_q == ST_SEARCH) begin
                hist_d = {hist_q[WIDTH-2:0], in_bit};
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end else if (mismatch) begin
                    match_d = '0;
                end else if (match_q == MATCH_LAST) begin
                    // An all-zero history satisfies any recurrence, so it must not lock.
                    match_d = '0;
                    if (hist_d != '0) begin
                        state_d   = ST_LOCKED;
                        win_pos_d = '0;
                        win_err_d = '0;
                    end
                end else begin
                    match_d = match_q + 1'b1;
                end
            end else begin
                // Free-run on the local prediction so one line error is counted once.
                hist_d    = {hist_q[WIDTH-2:0], pred};
                bit_inc   = 1'b1;
                err_inc   = mismatch;
                bit_err_d = mismatch;
                if (mismatch && (win_err_q == WERR_LAST)) begin
                    state_d   = ST_SEARCH;
                    fill_d    = '0;
                    match_d   = '0;
                    win_pos_d = '0;
                    win_err_d = '0;
                end else if (win_pos_q == WPOS_LAST) begin
                    win_pos_d = '0;
                    win_err_d = '0;
                end else begin
                    win_pos_d = win_pos_q + 1'b1;
                    win_err_d = win_err_q + WERR_W'(mismatch);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_pos_q <= '0;
            win_err_q <= '0;
            bit_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_pos_q <= win_pos_d;
            win_err_q <= win_err_d;
            bit_err_q <= bit_err_d;
        end
    end

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clear_counts),
        .count (err_count)
    );

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_bit_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bit_inc),
        .clr   (clear_counts),
        .count (bit_count)
    );

    assign locked  = (state_q == ST_LOCKED);
    assign bit_err = bit_err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized and directed bench for lfsr_checker against a stream-level model
module tb_lfsr_checker;

    localparam logic [31:0] TAPS = 32'h80200003;
    localparam logic [31:0] SEED = 32'h00003039;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clear_counts = 1'b0;
    logic        locked;
    logic        bit_err;
    logic [31:0] err_count;
    logic [31:0] bit_count;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state: received/predicted bit history, newest first
    bit     hq[$];
    bit     m_locked;
    bit     m_bit_err;
    int     m_fill;
    int     m_match;
    int     m_wpos;
    int     m_werr;
    longint m_err;
    longint m_bit;

    logic [31:0] g_state;

    lfsr_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .clear_counts (clear_counts),
        .locked       (locked),
        .bit_err      (bit_err),
        .err_count    (err_count),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hq.delete();
        m_locked = 0; m_bit_err = 0;
        m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
        m_err = 0; m_bit = 0;
    endtask

    task automatic model_clock(input logic v, input logic b, input logic clr);
        bit p;
        bit nz;
        bit ie;
        bit ib;
        p = 0; ie = 0; ib = 0;
        m_bit_err = 0;
        if (v) begin
            for (int k = 0; k < 32; k++)
                if (TAPS[k] && k < hq.size()) p ^= hq[k];
            if (!m_locked) begin
                hq.push_front(b);
                if (hq.size() > 32) void'(hq.pop_back());
                if (m_fill < 32) m_fill++;
                else begin
                    m_match = (b == p) ? m_match + 1 : 0;
                    if (m_match == 64) begin
                        nz = 0;
                        foreach (hq[i]) if (hq[i]) nz = 1;
                        m_match = 0;
                        if (nz) begin m_locked = 1; m_wpos = 0; m_werr = 0; end
                    end
                end
            end else begin
                hq.push_front(p);
                if (hq.size() > 32) void'(hq.pop_back());
                ib = 1;
                ie = (b != p);
                m_bit_err = ie;
                m_werr += int'(ie);
                if (m_werr == 8) begin
                    m_locked = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
                end else if (m_wpos == 127) begin
                    m_wpos = 0; m_werr = 0;
                end else m_wpos++;
            end
        end
        if (clr) begin
            m_err = longint'(ie);
            m_bit = longint'(ib);
        end else begin
            if (ie && m_err < 64'hFFFF_FFFF) m_err++;
            if (ib && m_bit < 64'hFFFF_FFFF) m_bit++;
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic clr);
        in_valid = v; in_bit = b; clear_counts = clr;
        @(posedge clk);
        #1;
        model_clock(v, b, clr);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear_counts = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic gen_bit(output logic b);
        b = ^(g_state & TAPS);
        g_state = {g_state[30:0], b};
    endtask

    task automatic test_reset();
        do_reset(2);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset.locked got %b expected 0", locked); end
        tests_run++;
        if (bit_err !== 1'b0) begin tests_failed++; $display("FAIL reset.bit_err got %b expected 0", bit_err); end
        tests_run++;
        if (err_count !== 32'd0) begin tests_failed++; $display("FAIL reset.err_count got %0d expected 0", err_count); end
        tests_run++;
        if (bit_count !== 32'd0) begin tests_failed++; $display("FAIL reset.bit_count got %0d expected 0", bit_count); end
    endtask

    task automatic test_lock_clean();
        logic b;
        int lock_at = 0;
        do_reset(2);
        g_state = SEED;
        for (int n = 1; n <= 200; n++) begin
            gen_bit(b);
            drive(1'b1, b, 1'b0);
            tests_run++;
            if (locked !== m_locked) begin
                tests_failed++; $display("FAIL lock_clean.locked bit %0d got %b expected %b", n, locked, m_locked);
            end
            if (lock_at == 0 && locked === 1'b1) lock_at = n;
        end
        tests_run++;
        if (lock_at != 96) begin tests_failed++; $display("FAIL lock_clean.lock_index got %0d expected 96", lock_at); end
        tests_run++;
        if (err_count !== 32'd0) begin tests_failed++; $display("FAIL lock_clean.err_count got %0d expected 0", err_count); end
        tests_run++;
        if (bit_count !== 32'd104) begin tests_failed++; $display("FAIL lock_clean.bit_count got %0d expected 104", bit_count); end
    endtask

    task automatic test_single_error();
        logic b;
        int pulses = 0;
        int pulse_at = 0;
        do_reset(2);
        g_state = SEED;
        for (int n = 1; n <= 200; n++) begin
            gen_bit(b);
            drive(1'b1, (n == 150) ? ~b : b, 1'b0);
            if (bit_err === 1'b1) begin pulses++; pulse_at = n; end
            tests_run++;
            if (bit_err !== m_bit_err) begin
                tests_failed++; $display("FAIL single_err.bit_err bit %0d got %b expected %b", n, bit_err, m_bit_err);
            end
        end
        tests_run++;
        if (pulses != 1 || pulse_at != 150) begin
            tests_failed++; $display("FAIL single_err.pulse got %0d pulses at %0d expected 1 at 150", pulses, pulse_at);
        end
        tests_run++;
        if (err_count !== 32'd1) begin tests_failed++; $display("FAIL single_err.err_count got %0d expected 1", err_count); end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL single_err.locked got %b expected 1", locked); end
    endtask

    task automatic test_burst_unlock();
        logic b;
        logic prev = 1'b0;
        int fall_at = 0;
        int relock_at = 0;
        do_reset(2);
        g_state = SEED;
        for (int n = 1; n <= 230; n++) begin
            gen_bit(b);
            drive(1'b1, (n >= 106 && n <= 113) ? ~b : b, 1'b0);
            tests_run++;
            if (locked !== m_locked) begin
                tests_failed++; $display("FAIL burst.locked bit %0d got %b expected %b", n, locked, m_locked);
            end
            if (fall_at == 0 && prev === 1'b1 && locked === 1'b0) fall_at = n;
            if (fall_at != 0 && relock_at == 0 && locked === 1'b1) relock_at = n;
            prev = locked;
        end
        tests_run++;
        if (fall_at != 113) begin tests_failed++; $display("FAIL burst.unlock_index got %0d expected 113", fall_at); end
        tests_run++;
        if (relock_at != 209) begin tests_failed++; $display("FAIL burst.relock_index got %0d expected 209", relock_at); end
        tests_run++;
        if (err_count !== 32'd8) begin tests_failed++; $display("FAIL burst.err_count got %0d expected 8", err_count); end
    endtask

    task automatic test_all_zero();
        int ever = 0;
        do_reset(2);
        for (int n = 1; n <= 300; n++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) ever++;
        end
        tests_run++;
        if (ever != 0) begin tests_failed++; $display("FAIL all_zero.locked got %0d locked cycles expected 0", ever); end
        tests_run++;
        if (bit_count !== 32'd0) begin tests_failed++; $display("FAIL all_zero.bit_count got %0d expected 0", bit_count); end
    endtask

    task automatic test_sparse_valid();
        logic b;
        int nbits = 0;
        int lock_at = 0;
        int xs = 0;
        do_reset(2);
        g_state = SEED;
        for (int c = 0; c < 600; c++) begin
            if (c % 3 == 2) begin
                gen_bit(b);
                nbits++;
                drive(1'b1, b, 1'b0);
            end else begin
                drive(1'b0, 1'bx, 1'b0);
            end
            if ($isunknown({locked, bit_err, err_count, bit_count})) xs++;
            if (lock_at == 0 && locked === 1'b1) lock_at = nbits;
        end
        tests_run++;
        if (lock_at != 96) begin tests_failed++; $display("FAIL sparse.lock_index got %0d expected 96", lock_at); end
        tests_run++;
        if (xs != 0) begin tests_failed++; $display("FAIL sparse.x_outputs got %0d cycles with X expected 0", xs); end
        tests_run++;
        if (bit_count !== 32'(m_bit)) begin tests_failed++; $display("FAIL sparse.bit_count got %0d expected %0d", bit_count, m_bit); end
    endtask

    task automatic test_clear_and_reset();
        logic b;
        do_reset(2);
        g_state = SEED;
        for (int n = 1; n <= 100; n++) begin
            gen_bit(b);
            drive(1'b1, b, 1'b0);
        end
        gen_bit(b);
        drive(1'b1, ~b, 1'b1);
        tests_run++;
        if (err_count !== 32'd1) begin tests_failed++; $display("FAIL clear.err_count got %0d expected 1", err_count); end
        tests_run++;
        if (bit_count !== 32'd1) begin tests_failed++; $display("FAIL clear.bit_count got %0d expected 1", bit_count); end
        tests_run++;
        if (locked !== 1'b1 || bit_err !== 1'b1) begin
            tests_failed++; $display("FAIL clear.state got locked=%b bit_err=%b expected 1 1", locked, bit_err);
        end
        gen_bit(b);
        rst_n = 1'b0; in_valid = 1'b1; in_bit = ~b;
        @(posedge clk);
        #1;
        tests_run++;
        if ({locked, bit_err, err_count, bit_count} !== 66'd0) begin
            tests_failed++;
            $display("FAIL midreset.outputs got locked=%b bit_err=%b err=%0d bits=%0d expected all 0", locked, bit_err, err_count, bit_count);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic b;
        logic v;
        logic e;
        logic clr;
        int   rate;
        for (int it = 0; it < 8; it++) begin
            do_reset(1);
            g_state = $urandom() | 32'h1;
            rate = $urandom_range(0, 12);
            for (int n = 0; n < 900; n++) begin
                v   = ($urandom_range(0, 3) != 0);
                e   = ($urandom_range(0, 99) < rate);
                clr = ($urandom_range(0, 79) == 0);
                if (v) begin
                    gen_bit(b);
                    drive(1'b1, e ? ~b : b, clr);
                end else begin
                    drive(1'b0, 1'($urandom()), clr);
                end
                tests_run++;
                if (locked !== m_locked || bit_err !== m_bit_err ||
                    err_count !== 32'(m_err) || bit_count !== 32'(m_bit)) begin
                    tests_failed++;
                    $display("FAIL random.it%0d cyc %0d got l=%b e=%b ec=%0d bc=%0d expected l=%b e=%b ec=%0d bc=%0d",
                             it, n, locked, bit_err, err_count, bit_count, m_locked, m_bit_err, m_err, m_bit);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_clean();
        test_single_error();
        test_burst_unlock();
        test_all_zero();
        test_sparse_valid();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
